cdc_tx_arbiter: RTL
===================

CDC_TX_ARBITER -- requirements
Module: cdc_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one async_fifo write port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload bits per beat.
REQ-003 SHALL have parameter ID_WIDTH, default $clog2(NUM_REQ), requester tag width.
REQ-004 SHALL have parameter MAX_BURST, default 8, maximum beats per grant.
REQ-005 SHALL have parameter STALL_LIMIT, default 16, idle cycles tolerated mid-burst.
REQ-006 SHALL have port w_clk, input, 1, sole clock (async_fifo write clock).
REQ-007 SHALL have port w_rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port req_valid, input, NUM_REQ, per-requester beat valid.
REQ-009 SHALL have port req_last, input, NUM_REQ, per-requester final-beat marker.
REQ-010 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, packed payloads; requester i occupies slice i.
REQ-011 SHALL have port req_ready, output, NUM_REQ, per-requester beat accept.
REQ-012 SHALL have port fifo_full, input, 1, async_fifo full flag.
REQ-013 SHALL have port fifo_w_en, output, 1, async_fifo write enable.
REQ-014 SHALL have port fifo_data, output, DATA_WIDTH+ID_WIDTH+1, {last, id, payload} to async_fifo data_in.
REQ-015 SHALL have port grant_id, output, ID_WIDTH, currently granted requester.
REQ-016 SHALL have port busy, output, 1, high while in GRANT.
REQ-017 SHALL have port stall_err, output, 1, sticky stall-timeout flag.
REQ-018 SHALL have port stall_clr, input, 1, clears stall_err.

Function
REQ-019 SHALL implement states IDLE and GRANT.
REQ-020 IDLE: when any req_valid high, SHALL pick first set bit at or after rr_ptr (wrapping modulo NUM_REQ), register grant_id, enter GRANT next cycle; no beat accepted in IDLE.
REQ-021 GRANT: beat transfers when req_valid[grant_id] && !fifo_full; only then req_ready[grant_id]=1 and fifo_w_en=1, same cycle (combinational from registered grant).
REQ-022 req_ready of all non-granted requesters SHALL be 0; fifo_w_en SHALL never assert while fifo_full=1.
REQ-023 fifo_data SHALL equal {req_last[g], g, req_data slice g} for g=grant_id.
REQ-024 Beat counter SHALL count transferred beats in GRANT, clear on entry.
REQ-025 Release SHALL occur on transferred beat with req_last=1, or on the MAX_BURST-th beat (forced; fifo_data last bit forced to 1 on that beat).
REQ-026 Stall counter SHALL increment each GRANT cycle with req_valid[grant_id]=0, clear on any transfer; on reaching STALL_LIMIT SHALL release and set stall_err.
REQ-027 fifo_full-caused waits SHALL NOT increment the stall counter.
REQ-028 On release SHALL return to IDLE and set rr_ptr = (grant_id+1) mod NUM_REQ; minimum 1 IDLE cycle between grants.
REQ-029 stall_err SHALL stay set until stall_clr=1; simultaneous set and clear: set wins.

Reset
REQ-030 w_rst SHALL asynchronously force IDLE, rr_ptr=0, grant_id=0, counters=0, busy=0, stall_err=0, req_ready=0, fifo_w_en=0.
REQ-031 Reset mid-burst SHALL abandon the burst; no partial-burst recovery.

Structure
REQ-032 Shared package SHALL hold the state enum (IDLE, GRANT) and default MAX_BURST/STALL_LIMIT constants.
REQ-033 Round-robin priority picker SHALL be one sub-module, rr_picker (req vector + pointer -> index + found).

Verification
REQ-034 req_valid=0b0001, 3 beats, last on 3rd, fifo_full=0 -> grant_id=0 one cycle after request, fifo_w_en high 3 consecutive cycles, busy drops following cycle.
REQ-035 All four valid, each 1-beat -> grants in order 0,1,2,3,0; each fifo_data id matches.
REQ-036 Requester 1 streams 12 beats, no last -> release after 8th beat with last bit forced 1, rr_ptr=2.
REQ-037 fifo_full=1 for 20 cycles mid-burst -> no fifo_w_en, no stall_err, burst resumes when full drops.
REQ-038 Granted requester drops valid 16 cycles -> release, stall_err=1 until stall_clr pulse.
REQ-039 w_rst asserted mid-burst between clock edges -> outputs 0 immediately, state IDLE, rr_ptr=0.

Source files
------------

// File: rtl/cdc_tx_arbiter_pkg.sv
// Shared types and default sizing for the async-FIFO write-port arbiter.
//   state_t          : arbiter FSM states (IDLE, GRANT)
//   DEF_MAX_BURST    : default beats allowed per grant
//   DEF_STALL_LIMIT  : default idle cycles tolerated inside a burst
package cdc_tx_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int unsigned DEF_MAX_BURST   = 8;
   localparam int unsigned DEF_STALL_LIMIT = 16;

endpackage

// File: rtl/cdc_tx_arbiter_rr_picker.sv
// Round-robin priority picker: returns the first set request bit at or after
// ptr, wrapping modulo NUM_REQ.
//   req   : request vector
//   ptr   : starting position of the search
//   idx   : winning requester index (valid when found=1)
//   found : at least one request bit is set
module rr_picker #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [ID_WIDTH-1:0] idx,
   output logic                found
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [ID_WIDTH:0]    sum;

   // Rotate so that bit 0 is the requester at ptr, then take the lowest set bit.
   always_comb begin
      req_dbl = {req, req} >> ptr;
      req_rot = req_dbl[NUM_REQ-1:0];
      found   = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            found = 1'b1;
            sum   = {1'b0, ptr} + (ID_WIDTH+1)'(i);
         end
      end
      if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
         sum = sum - (ID_WIDTH+1)'(NUM_REQ);
      end
      idx = sum[ID_WIDTH-1:0];
   end

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port among NUM_REQ
// requesters, with burst limit and mid-burst stall timeout.
//   w_clk, w_rst        : write clock, async active-high reset
//   req_valid/last/data : per-requester beat stream (data slice i = requester i)
//   req_ready           : per-requester beat accept (only granted one)
//   fifo_full           : async_fifo full flag
//   fifo_w_en/fifo_data : async_fifo write, data = {last, id, payload}
//   grant_id, busy      : current grant and GRANT-state indicator
//   stall_err/stall_clr : sticky stall-timeout flag and its clear
module cdc_tx_arbiter
   import cdc_tx_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ID_WIDTH    = $clog2(NUM_REQ),
   parameter int unsigned MAX_BURST   = DEF_MAX_BURST,
   parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT
) (
   input  logic                             w_clk,
   input  logic                             w_rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic                             fifo_full,
   output logic                             fifo_w_en,
   output logic [DATA_WIDTH+ID_WIDTH:0]     fifo_data,
   output logic [ID_WIDTH-1:0]              grant_id,
   output logic                             busy,
   output logic                             stall_err,
   input  logic                             stall_clr
);

   localparam int unsigned BEAT_W  = $clog2(MAX_BURST + 1);
   localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

   state_t                  state_q, state_d;
   logic [ID_WIDTH-1:0]     rr_ptr_q;
   logic [BEAT_W-1:0]       beat_cnt_q;
   logic [STALL_W-1:0]      stall_cnt_q;
   logic [ID_WIDTH-1:0]     pick_idx;
   logic                    pick_found;
   logic                    gnt_valid;
   logic                    gnt_last;
   logic [DATA_WIDTH-1:0]   gnt_data;
   logic                    in_grant;
   logic                    xfer;
   logic                    forced_last;
   logic                    beat_last;
   logic                    stall_hit;
   logic                    release_c;
   logic [ID_WIDTH-1:0]     next_ptr;

   rr_picker #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_picker (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Granted requester's stream and the transfer/release decisions.
   always_comb begin
      gnt_valid = req_valid[grant_id];
      gnt_last  = req_last[grant_id];
      gnt_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_WIDTH'(i)) begin
            gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      in_grant    = (state_q == GRANT);
      xfer        = in_grant && gnt_valid && !fifo_full;
      forced_last = (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
      beat_last   = gnt_last || forced_last;
      // Waits caused by fifo_full do not count as stall cycles.
      stall_hit   = in_grant && !gnt_valid &&
                    (stall_cnt_q == STALL_W'(STALL_LIMIT - 1));
      release_c   = (xfer && beat_last) || stall_hit;
      next_ptr    = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                         : grant_id + ID_WIDTH'(1);
   end

   // State register.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_found) state_d = GRANT;
         GRANT:   if (release_c)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the registered grant.
   always_comb begin
      req_ready = '0;
      fifo_w_en = 1'b0;
      busy      = in_grant;
      fifo_data = {beat_last, grant_id, gnt_data};
      if (xfer) begin
         req_ready[grant_id] = 1'b1;
         fifo_w_en           = 1'b1;
      end
   end

   // Grant id, round-robin pointer, counters and sticky stall flag.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         grant_id    <= '0;
         rr_ptr_q    <= '0;
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
         stall_err   <= 1'b0;
      end else begin
         if (!in_grant) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            if (pick_found) grant_id <= pick_idx;
         end else begin
            if (xfer) begin
               beat_cnt_q  <= beat_cnt_q + BEAT_W'(1);
               stall_cnt_q <= '0;
            end else if (!gnt_valid) begin
               stall_cnt_q <= stall_cnt_q + STALL_W'(1);
            end
            if (release_c) rr_ptr_q <= next_ptr;
         end
         // Set has priority over a simultaneous clear.
         if (stall_hit)      stall_err <= 1'b1;
         else if (stall_clr) stall_err <= 1'b0;
      end
   end

endmodule
